// File: rtl/axis_packet_dispatcher_demultiplexeur.sv
// Ingress splitter: routes the first PARSE_BEATS beats of each packet to the parser,
// then either forwards the remainder to the output multiplexer or drops it.
//
// state              | meaning
// IDLE               | waiting for a packet; clears beat count and pkt_done
// PARSE_DATA         | header beats flow to the parser
// CONTROL            | waiting for the keep/drop verdict
// SEND_ANALYSED_DATA | parser emitting the analysed header downstream
// SEND_REMAIN        | remaining beats flow to the multiplexer
// DROP               | remaining beats are consumed and discarded
module axis_packet_dispatcher_demultiplexeur #(
  parameter int                     AXIS_DATA_WIDTH    = 64,
  parameter int                     AXIS_KEEP_WIDTH    = AXIS_DATA_WIDTH/8,
  parameter int                     AXIS_DEST_WIDTH    = 9,
  parameter int                     PARSE_BEATS        = 2,
  parameter int                     STATE_WIDTH        = 3,
  parameter logic [STATE_WIDTH-1:0] IDLE               = 3'd0,
  parameter logic [STATE_WIDTH-1:0] PARSE_DATA         = 3'd1,
  parameter logic [STATE_WIDTH-1:0] CONTROL            = 3'd2,
  parameter logic [STATE_WIDTH-1:0] SEND_ANALYSED_DATA = 3'd3,
  parameter logic [STATE_WIDTH-1:0] SEND_REMAIN        = 3'd4,
  parameter logic [STATE_WIDTH-1:0] DROP               = 3'd5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [AXIS_DEST_WIDTH-1:0] s_axis_tdest,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_parser_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] m_axis_parser_tkeep,
  output logic                       m_axis_parser_tvalid,
  output logic                       m_axis_parser_tlast,
  input  logic                       m_axis_parser_tready,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_remain_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] m_axis_remain_tkeep,
  output logic [AXIS_DEST_WIDTH-1:0] m_axis_remain_tdest,
  output logic                       m_axis_remain_tvalid,
  output logic                       m_axis_remain_tlast,
  input  logic                       m_axis_remain_tready,
  input  logic                       decision_valid,
  input  logic                       decision_drop,
  input  logic                       analysed_done,
  output logic [STATE_WIDTH-1:0]     state
);

  localparam int CNT_W = $clog2(PARSE_BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_HDR_CNT = CNT_W'(PARSE_BEATS - 1);

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE     = IDLE,
    ST_PARSE    = PARSE_DATA,
    ST_CONTROL  = CONTROL,
    ST_ANALYSED = SEND_ANALYSED_DATA,
    ST_REMAIN   = SEND_REMAIN,
    ST_DROP     = DROP
  } state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       pkt_done_q, pkt_done_d;
  logic [AXIS_DEST_WIDTH-1:0] dest_q, dest_d;

  logic s_ready;
  logic parser_valid;
  logic remain_valid;
  logic parser_last;
  logic s_xfer;

  assign parser_last = s_axis_tlast || (cnt_q == LAST_HDR_CNT);
  assign s_xfer      = s_axis_tvalid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pkt_done_q <= 1'b0;
      dest_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pkt_done_q <= pkt_done_d;
      dest_q     <= dest_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pkt_done_d   = pkt_done_q;
    dest_d       = dest_q;
    s_ready      = 1'b0;
    parser_valid = 1'b0;
    remain_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d      = '0;
        pkt_done_d = 1'b0;
        if (s_axis_tvalid) begin
          state_d = ST_PARSE;
        end
      end

      ST_PARSE: begin
        parser_valid = s_axis_tvalid;
        s_ready      = m_axis_parser_tready;
        if (s_xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == '0) begin
            dest_d = s_axis_tdest;
          end
          if (parser_last) begin
            pkt_done_d = s_axis_tlast;
            state_d    = ST_CONTROL;
          end
        end
      end

      ST_CONTROL: begin
        if (decision_valid) begin
          if (decision_drop) begin
            state_d = pkt_done_q ? ST_IDLE : ST_DROP;
          end else begin
            state_d = ST_ANALYSED;
          end
        end
      end

      ST_ANALYSED: begin
        if (analysed_done) begin
          state_d = pkt_done_q ? ST_IDLE : ST_REMAIN;
        end
      end

      ST_REMAIN: begin
        remain_valid = s_axis_tvalid;
        s_ready      = m_axis_remain_tready;
        if (s_xfer && s_axis_tlast) begin
          state_d = ST_IDLE;
        end
      end

      ST_DROP: begin
        s_ready = 1'b1;
        if (s_xfer && s_axis_tlast) begin
          state_d = ST_IDLE;
        end
      end

      // unused encodings recover to IDLE
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign s_axis_tready        = s_ready;

  assign m_axis_parser_tdata  = s_axis_tdata;
  assign m_axis_parser_tkeep  = s_axis_tkeep;
  assign m_axis_parser_tvalid = parser_valid;
  assign m_axis_parser_tlast  = parser_last;

  assign m_axis_remain_tdata  = s_axis_tdata;
  assign m_axis_remain_tkeep  = s_axis_tkeep;
  assign m_axis_remain_tdest  = dest_q;
  assign m_axis_remain_tvalid = remain_valid;
  assign m_axis_remain_tlast  = s_axis_tlast;

  assign state                = state_q;

endmodule

// File: tb/tb_axis_packet_dispatcher_demultiplexeur.sv
// Randomized bench for the packet dispatcher demultiplexer: per-packet expected
// parser/remain beat streams and state progression are built from packet length and verdict.
module tb_axis_packet_dispatcher_demultiplexeur;

  localparam int P = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic [8:0]  s_axis_tdest;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [63:0] m_axis_parser_tdata;
  logic [7:0]  m_axis_parser_tkeep;
  logic        m_axis_parser_tvalid;
  logic        m_axis_parser_tlast;
  logic        m_axis_parser_tready;
  logic [63:0] m_axis_remain_tdata;
  logic [7:0]  m_axis_remain_tkeep;
  logic [8:0]  m_axis_remain_tdest;
  logic        m_axis_remain_tvalid;
  logic        m_axis_remain_tlast;
  logic        m_axis_remain_tready;
  logic        decision_valid;
  logic        decision_drop;
  logic        analysed_done;
  logic [2:0]  state;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [8:0]  dest;
  } beat_t;

  int vectors = 0;
  int errors  = 0;

  axis_packet_dispatcher_demultiplexeur dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .s_axis_tdata         (s_axis_tdata),
    .s_axis_tkeep         (s_axis_tkeep),
    .s_axis_tdest         (s_axis_tdest),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tlast         (s_axis_tlast),
    .s_axis_tready        (s_axis_tready),
    .m_axis_parser_tdata  (m_axis_parser_tdata),
    .m_axis_parser_tkeep  (m_axis_parser_tkeep),
    .m_axis_parser_tvalid (m_axis_parser_tvalid),
    .m_axis_parser_tlast  (m_axis_parser_tlast),
    .m_axis_parser_tready (m_axis_parser_tready),
    .m_axis_remain_tdata  (m_axis_remain_tdata),
    .m_axis_remain_tkeep  (m_axis_remain_tkeep),
    .m_axis_remain_tdest  (m_axis_remain_tdest),
    .m_axis_remain_tvalid (m_axis_remain_tvalid),
    .m_axis_remain_tlast  (m_axis_remain_tlast),
    .m_axis_remain_tready (m_axis_remain_tready),
    .decision_valid       (decision_valid),
    .decision_drop        (decision_drop),
    .analysed_done        (analysed_done),
    .state                (state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    s_axis_tdata         = '0;
    s_axis_tkeep         = '0;
    s_axis_tdest         = '0;
    s_axis_tvalid        = 1'b0;
    s_axis_tlast         = 1'b0;
    m_axis_parser_tready = 1'b0;
    m_axis_remain_tready = 1'b0;
    decision_valid       = 1'b0;
    decision_drop        = 1'b0;
    analysed_done        = 1'b0;
  endtask

  // rdy_mode: 0 = sinks always ready, 1 = toggle each cycle, 2 = random
  task automatic run_packet(input int len, input bit drop, input int rdy_mode, input bit abort_remain);
    logic [63:0] bd [16];
    logic [7:0]  bk [16];
    logic [8:0]  dest;
    beat_t       exp_p[$], got_p[$], exp_r[$], got_r[$];
    logic [2:0]  exp_s[$], got_s[$];
    logic [2:0]  last_s, st;
    logic [2:0]  exp_ctl;
    int          hdr, sent, cyc;
    bit          done, xfer;

    dest = 9'($urandom_range(0, 511));
    if (len == 5 && !drop && rdy_mode == 0) dest = 9'h1A5;
    for (int i = 0; i < len; i++) begin
      bd[i] = {$urandom, $urandom};
      bk[i] = 8'($urandom);
    end

    hdr = (len < P) ? len : P;
    for (int i = 0; i < hdr; i++)
      exp_p.push_back('{d: bd[i], k: bk[i], l: (i == hdr - 1), dest: 9'd0});
    if (!drop)
      for (int i = hdr; i < len; i++)
        exp_r.push_back('{d: bd[i], k: bk[i], l: (i == len - 1), dest: dest});
    exp_s.push_back(3'd1);
    exp_s.push_back(3'd2);
    if (drop) begin
      if (len > P) exp_s.push_back(3'd5);
    end else begin
      exp_s.push_back(3'd3);
      if (len > P) exp_s.push_back(3'd4);
    end
    exp_s.push_back(3'd0);

    sent = 0; cyc = 0; done = 0; xfer = 0; last_s = 3'd0;
    while (!done && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (xfer || !s_axis_tvalid)
        s_axis_tvalid = (sent < len) && ($urandom_range(0, 3) != 0);
      if (sent < len) begin
        s_axis_tdata = bd[sent];
        s_axis_tkeep = bk[sent];
        s_axis_tdest = (sent == 0) ? dest : 9'($urandom);
        s_axis_tlast = (sent == len - 1);
      end
      case (rdy_mode)
        0:       begin m_axis_parser_tready = 1'b1;       m_axis_remain_tready = 1'b1; end
        1:       begin m_axis_parser_tready = cyc[0];     m_axis_remain_tready = ~cyc[0]; end
        default: begin m_axis_parser_tready = 1'($urandom); m_axis_remain_tready = 1'($urandom); end
      endcase
      decision_valid = ($urandom_range(0, 2) == 0);
      decision_drop  = drop;
      analysed_done  = ($urandom_range(0, 3) == 0);

      @(negedge clk);
      st = state;
      if (st != last_s) begin
        got_s.push_back(st);
        last_s = st;
      end
      case (st)
        3'd1:    exp_ctl = {m_axis_parser_tready, s_axis_tvalid, 1'b0};
        3'd4:    exp_ctl = {m_axis_remain_tready, 1'b0, s_axis_tvalid};
        3'd5:    exp_ctl = 3'b100;
        default: exp_ctl = 3'b000;
      endcase
      check_val("ready_valid_by_state",
                128'({s_axis_tready, m_axis_parser_tvalid, m_axis_remain_tvalid}), 128'(exp_ctl));
      xfer = s_axis_tvalid && s_axis_tready;
      if (xfer) sent++;
      if (m_axis_parser_tvalid && m_axis_parser_tready)
        got_p.push_back('{d: m_axis_parser_tdata, k: m_axis_parser_tkeep,
                          l: m_axis_parser_tlast, dest: 9'd0});
      if (m_axis_remain_tvalid && m_axis_remain_tready)
        got_r.push_back('{d: m_axis_remain_tdata, k: m_axis_remain_tkeep,
                          l: m_axis_remain_tlast, dest: m_axis_remain_tdest});

      if (abort_remain && st == 3'd4 && s_axis_tvalid) begin
        #2 rst_n = 1'b0;
        #1;
        check_val("async_reset_outputs",
                  128'({state, s_axis_tready, m_axis_parser_tvalid, m_axis_remain_tvalid}), 128'(0));
        check_val("abort_hdr_count", 128'(got_p.size()), 128'(exp_p.size()));
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      if (sent == len && st == 3'd0) done = 1;
    end

    check_val("packet_completed", 128'(done), 128'(1));
    check_val("parser_beat_count", 128'(got_p.size()), 128'(exp_p.size()));
    for (int i = 0; i < exp_p.size() && i < got_p.size(); i++)
      check_val("parser_beat", 128'(got_p[i]), 128'(exp_p[i]));
    check_val("remain_beat_count", 128'(got_r.size()), 128'(exp_r.size()));
    for (int i = 0; i < exp_r.size() && i < got_r.size(); i++)
      check_val("remain_beat", 128'(got_r[i]), 128'(exp_r[i]));
    check_val("state_trace_len", 128'(got_s.size()), 128'(exp_s.size()));
    for (int i = 0; i < exp_s.size() && i < got_s.size(); i++)
      check_val("state_trace", 128'(got_s[i]), 128'(exp_s[i]));
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outputs",
              128'({state, s_axis_tready, m_axis_parser_tvalid, m_axis_remain_tvalid}), 128'(0));
    rst_n = 1'b1;

    run_packet(5, 1'b0, 0, 1'b0);
    run_packet(1, 1'b0, 0, 1'b0);
    run_packet(6, 1'b1, 0, 1'b0);
    run_packet(7, 1'b0, 1, 1'b0);
    run_packet(2, 1'b0, 0, 1'b0);
    run_packet(2, 1'b1, 1, 1'b0);
    run_packet(1, 1'b1, 2, 1'b0);
    run_packet(3, 1'b1, 1, 1'b0);
    for (int n = 0; n < 40; n++)
      run_packet($urandom_range(1, 10), 1'($urandom), $urandom_range(0, 2), 1'b0);
    run_packet(6, 1'b0, 0, 1'b1);
    run_packet(4, 1'b0, 2, 1'b0);
    run_packet(8, 1'b1, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
